conv_mac: RTL and testbench

CONV_MAC -- requirements
Module: conv_mac

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_mult.sv | 25 ++
 rtl/conv_mac.sv | 95 +++++++++
 tb/tb_conv_mac.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared constants for the 5-tap convolution multiply-accumulate block.
//   DATA_W_DEF : signed width of each sample and weight
//   TAPS_DEF   : number of sample/weight pairs
//   OUT_W_DEF  : signed width of the accumulated dot product
//   PROD_W_DEF : width of one full-precision product (2*DATA_W)
// No ports; imported by conv_mult and conv_mac.
// -----------------------------------------------------------------------------
package conv_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int TAPS_DEF   = 5;
   localparam int OUT_W_DEF  = 19;
   localparam int PROD_W_DEF = 2 * DATA_W_DEF;

endpackage : conv_pkg

// File: rtl/conv_mult.sv
// -----------------------------------------------------------------------------
// conv_mult
// Purely combinational signed DATA_W x DATA_W multiplier, one per tap.
// Ports:
//   i_a : signed multiplicand (sample)
//   i_b : signed multiplier (weight)
//   o_p : signed full-precision product, PROD_W bits
// -----------------------------------------------------------------------------
module conv_mult
   import conv_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int PROD_W = PROD_W_DEF
) (
   input  logic signed [DATA_W-1:0] i_a,
   input  logic signed [DATA_W-1:0] i_b,
   output logic signed [PROD_W-1:0] o_p
);

   // Operands are widened to the product width first so the multiply is done
   // at full precision; the low PROD_W bits of the sign-extended product are
   // exactly the true signed product.
   assign o_p = PROD_W'(i_a) * PROD_W'(i_b);

endmodule : conv_mult

// File: rtl/conv_mac.sv
// -----------------------------------------------------------------------------
// conv_mac
// Registered 5-tap signed dot product: out = sum(xi * wi), one-cycle latency,
// full precision, no saturation.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst    : synchronous active-high reset, clears out, overrides en
//   en     : compute enable; when low, out holds its value
//   x0..x4 : signed samples
//   w0..w4 : signed weights (xi pairs only with wi)
//   out    : signed registered dot product, OUT_W bits
// -----------------------------------------------------------------------------
module conv_mac
   import conv_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TAPS   = TAPS_DEF,
   parameter int OUT_W  = OUT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] x0,
   input  logic signed [DATA_W-1:0] x1,
   input  logic signed [DATA_W-1:0] x2,
   input  logic signed [DATA_W-1:0] x3,
   input  logic signed [DATA_W-1:0] x4,
   input  logic signed [DATA_W-1:0] w0,
   input  logic signed [DATA_W-1:0] w1,
   input  logic signed [DATA_W-1:0] w2,
   input  logic signed [DATA_W-1:0] w3,
   input  logic signed [DATA_W-1:0] w4,
   output logic signed [OUT_W-1:0]  out
);

   localparam int PROD_W = 2 * DATA_W;

   logic signed [DATA_W-1:0] w_x    [TAPS];
   logic signed [DATA_W-1:0] w_w    [TAPS];
   logic signed [PROD_W-1:0] w_prod [TAPS];
   logic signed [OUT_W-1:0]  w_ext  [TAPS];

   logic signed [OUT_W-1:0]  w_sum01;
   logic signed [OUT_W-1:0]  w_sum23;
   logic signed [OUT_W-1:0]  w_sum0123;
   logic signed [OUT_W-1:0]  w_sum;

   logic signed [OUT_W-1:0]  r_out;

   assign w_x[0] = x0;
   assign w_x[1] = x1;
   assign w_x[2] = x2;
   assign w_x[3] = x3;
   assign w_x[4] = x4;

   assign w_w[0] = w0;
   assign w_w[1] = w1;
   assign w_w[2] = w2;
   assign w_w[3] = w3;
   assign w_w[4] = w4;

   for (genvar g = 0; g < TAPS; g++) begin : g_tap
      conv_mult #(
         .DATA_W (DATA_W),
         .PROD_W (PROD_W)
      ) u_mult (
         .i_a (w_x[g]),
         .i_b (w_w[g]),
         .o_p (w_prod[g])
      );

      // Sign-extend each product to the accumulator width before summing so
      // no partial sum can wrap.
      assign w_ext[g] = OUT_W'(w_prod[g]);
   end

   // Balanced adder tree; tap 4 joins at the last level.
   assign w_sum01   = w_ext[0] + w_ext[1];
   assign w_sum23   = w_ext[2] + w_ext[3];
   assign w_sum0123 = w_sum01 + w_sum23;
   assign w_sum     = w_sum0123 + w_ext[4];

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment for registered state so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (rst) begin
         r_out <= '0;
      end else if (en) begin
         r_out <= w_sum;
      end
   end

   assign out = r_out;

endmodule : conv_mac

// File: tb/tb_conv_mac.sv
// -----------------------------------------------------------------------------
// tb_conv_mac
// Self-checking bench for conv_mac. Stimulus is applied just after a rising
// edge, the expected register value is pushed onto a scoreboard queue, and
// after the next rising edge the expected value is popped and compared.
// -----------------------------------------------------------------------------
module tb_conv_mac;

   localparam int DW = 8;
   localparam int OW = 19;

   typedef int vec_t [5];

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic signed [DW-1:0] x [5];
   logic signed [DW-1:0] w [5];
   logic signed [OW-1:0] out;

   int total = 0;
   int bad   = 0;

   logic signed [OW-1:0] sb_q [$];
   logic signed [OW-1:0] model_out;
   logic signed [OW-1:0] exp_v;

   always #5 clk = ~clk;

   conv_mac #(
      .DATA_W (DW),
      .TAPS   (5),
      .OUT_W  (OW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .x0  (x[0]),
      .x1  (x[1]),
      .x2  (x[2]),
      .x3  (x[3]),
      .x4  (x[4]),
      .w0  (w[0]),
      .w1  (w[1]),
      .w2  (w[2]),
      .w3  (w[3]),
      .w4  (w[4]),
      .out (out)
   );

   // Apply one set of inputs and push the value the output register must
   // hold after the coming rising edge.
   task automatic drive(input logic r, input logic e, input vec_t xs, input vec_t ws);
      int acc;
      acc = 0;
      rst = r;
      en  = e;
      for (int i = 0; i < 5; i++) begin
         x[i] = DW'(xs[i]);
         w[i] = DW'(ws[i]);
         acc += int'(x[i]) * int'(w[i]);
      end
      if (r)
         model_out = '0;
      else if (e)
         model_out = OW'(acc);
      sb_q.push_back(model_out);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      drive(1'b1, 1'b0, '{3, 4, 5, 6, 7}, '{1, 2, 3, 4, 5});
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (out !== exp_v) begin
         bad++;
         $display("FAIL reset_first: got %0d expected %0d", out, exp_v);
      end
      drive(1'b1, 1'b0, '{-9, 4, 5, 6, 7}, '{1, 2, -3, 4, 5});
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (out !== exp_v) begin
         bad++;
         $display("FAIL reset_hold: got %0d expected %0d", out, exp_v);
      end
   endtask

   task automatic test_ref_vector;
      drive(1'b0, 1'b1, '{1, 1, 1, 1, 1}, '{-127, 44, 32, -25, 33});
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (out !== exp_v || out !== -19'sd43) begin
         bad++;
         $display("FAIL ref_vector: got %0d expected %0d", out, exp_v);
      end
   endtask

   task automatic test_extremes;
      drive(1'b0, 1'b1, '{-128, -128, -128, -128, -128}, '{-128, -128, -128, -128, -128});
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (out !== exp_v || out !== 19'sd81920) begin
         bad++;
         $display("FAIL max_positive: got %0d expected %0d", out, exp_v);
      end
      drive(1'b0, 1'b1, '{127, 127, 127, 127, 127}, '{-128, -128, -128, -128, -128});
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (out !== exp_v || out !== -19'sd81280) begin
         bad++;
         $display("FAIL max_negative: got %0d expected %0d", out, exp_v);
      end
   endtask

   task automatic test_hold;
      vec_t rx;
      vec_t rw;
      drive(1'b0, 1'b1, '{1, 1, 1, 1, 1}, '{1, 1, 1, 1, 1});
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (out !== exp_v || out !== 19'sd5) begin
         bad++;
         $display("FAIL hold_load: got %0d expected %0d", out, exp_v);
      end
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 5; i++) begin
            rx[i] = int'($urandom_range(0, 255)) - 128;
            rw[i] = int'($urandom_range(0, 255)) - 128;
         end
         drive(1'b0, 1'b0, rx, rw);
         tick();
         exp_v = sb_q.pop_front();
         total++;
         if (out !== exp_v || out !== 19'sd5) begin
            bad++;
            $display("FAIL hold_cycle%0d: got %0d expected %0d", c, out, exp_v);
         end
      end
   endtask

   task automatic test_reset_priority;
      drive(1'b1, 1'b1, '{10, -20, 30, -40, 50}, '{7, 7, 7, 7, 7});
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (out !== exp_v || out !== 19'sd0) begin
         bad++;
         $display("FAIL rst_over_en: got %0d expected %0d", out, exp_v);
      end
      drive(1'b0, 1'b1, '{10, -20, 30, -40, 50}, '{7, 7, 7, 7, 7});
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (out !== exp_v || out !== 19'sd210) begin
         bad++;
         $display("FAIL rst_release: got %0d expected %0d", out, exp_v);
      end
   endtask

   task automatic test_back_to_back;
      vec_t bx [3];
      vec_t bw [3];
      bx[0] = '{2, 0, 0, 0, 0};     bw[0] = '{3, 9, 9, 9, 9};
      bx[1] = '{0, 0, 0, 0, -5};    bw[1] = '{9, 9, 9, 9, 11};
      bx[2] = '{1, 2, 3, 4, 5};     bw[2] = '{-1, 2, -3, 4, -5};
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, bx[k], bw[k]);
         tick();
         exp_v = sb_q.pop_front();
         total++;
         if (out !== exp_v) begin
            bad++;
            $display("FAIL back_to_back%0d: got %0d expected %0d", k, out, exp_v);
         end
      end
   endtask

   task automatic test_random;
      vec_t rx;
      vec_t rw;
      logic re;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 5; i++) begin
            rx[i] = int'($urandom_range(0, 255)) - 128;
            rw[i] = int'($urandom_range(0, 255)) - 128;
         end
         re = (k % 3 != 2);
         drive(1'b0, re, rx, rw);
         tick();
         exp_v = sb_q.pop_front();
         total++;
         if (out !== exp_v) begin
            bad++;
            $display("FAIL random%0d: got %0d expected %0d", k, out, exp_v);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         x[i] = '0;
         w[i] = '0;
      end
      model_out = '0;
      test_reset();
      test_ref_vector();
      test_extremes();
      test_hold();
      test_reset_priority();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_conv_mac
